// File: rtl/icache_pkg.sv
// icache shared package: address width macros, FSM state type and sizing helper.
// Optional feature macro used by the design: ICACHE_STATS_EN.
`ifndef ICACHE_DEFINES_SVH
`define ICACHE_DEFINES_SVH
`define ADDR 31:0
`define INSTRLEN 31:0
`endif

package icache_pkg;

  typedef enum logic {
    S_IDLE,
    S_REFILL
  } state_e;

  // Word counter width; a one-word line still needs a 1-bit counter.
  function automatic int cnt_width(input int offset_bits);
    return (offset_bits > 0) ? offset_bits : 1;
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// icache line storage: valid bits, tags and data words.
// Combinational read port; one synchronous write port that writes a word and
// can set valid/tag, plus a single-line invalidate. Reset clears all valid bits.
import icache_pkg::*;

module icache_line_array #(
  parameter int INDEX_BITS  = 6,
  parameter int LINE_WORDS  = 4,
  parameter int TAG_BITS    = 20,
  parameter int CNT_W       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  input  logic [CNT_W-1:0]      rd_offset,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [`INSTRLEN]      rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [CNT_W-1:0]      wr_offset,
  input  logic [`INSTRLEN]      wr_data,
  input  logic                  set_en,
  input  logic [TAG_BITS-1:0]   set_tag,
  input  logic                  clr_en,
  input  logic [INDEX_BITS-1:0] clr_index
);

  localparam int LINES = 2 ** INDEX_BITS;

  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [`INSTRLEN]    data_mem [LINES][LINE_WORDS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index][rd_offset];

  // Valid-bit next state: invalidate on miss launch, set on final refill word.
  always_comb begin
    valid_d = valid_q;
    if (clr_en) valid_d[clr_index] = 1'b0;
    if (set_en) valid_d[wr_index]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag/data storage carries no reset; valid bits gate every hit.
  always_ff @(posedge clk) begin
    if (wr_en)  data_mem[wr_index][wr_offset] <= wr_data;
    if (set_en) tag_mem[wr_index]             <= set_tag;
  end

endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with word-by-word line refill.
// Optional statistics outputs (stat_hits, stat_misses) are built when
// ICACHE_STATS_EN is defined.
import icache_pkg::*;

module icache #(
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             fetch_valid,
  input  logic [`ADDR]     fetch_pc,
  output logic             fetch_hit,
  output logic [`INSTRLEN] fetch_instr,
`ifdef ICACHE_STATS_EN
  output logic [31:0]      stat_hits,
  output logic [31:0]      stat_misses,
`endif
  input  logic             flush,
  output logic             mem_req,
  output logic [`ADDR]     mem_addr,
  input  logic             mem_ack,
  input  logic [`INSTRLEN] mem_data
);

  localparam int OFFSET_BITS = $clog2(LINE_WORDS);
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS - 2;
  localparam int CNT_W       = cnt_width(OFFSET_BITS);
  localparam logic [31:0] LOW_MASK = 32'((LINE_WORDS * 4) - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [`ADDR]        base_q, base_d;

  logic [TAG_BITS-1:0]   pc_tag, base_tag, rd_tag;
  logic [INDEX_BITS-1:0] pc_index, base_index;
  logic [CNT_W-1:0]      pc_offset;
  logic [`ADDR]          line_base;
  logic                  rd_valid;
  logic [`INSTRLEN]      rd_data;
  logic                  wr_en, set_en, clr_en, launch;

  assign pc_tag     = fetch_pc[31 -: TAG_BITS];
  assign pc_index   = fetch_pc[OFFSET_BITS + 2 +: INDEX_BITS];
  assign line_base  = fetch_pc & ~LOW_MASK;
  assign base_tag   = base_q[31 -: TAG_BITS];
  assign base_index = base_q[OFFSET_BITS + 2 +: INDEX_BITS];

  if (OFFSET_BITS > 0) begin : g_off
    assign pc_offset = fetch_pc[2 +: OFFSET_BITS];
  end else begin : g_no_off
    assign pc_offset = '0;
  end

  icache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .LINE_WORDS (LINE_WORDS),
    .TAG_BITS   (TAG_BITS),
    .CNT_W      (CNT_W)
  ) u_lines (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (pc_index),
    .rd_offset (pc_offset),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_index  (base_index),
    .wr_offset (cnt_q),
    .wr_data   (mem_data),
    .set_en    (set_en),
    .set_tag   (base_tag),
    .clr_en    (clr_en),
    .clr_index (pc_index)
  );

  assign fetch_hit   = fetch_valid & rd_valid & (rd_tag == pc_tag);
  assign fetch_instr = fetch_hit ? rd_data : '0;
  assign mem_req     = (state_q == S_REFILL);
  assign mem_addr    = mem_req ? (base_q + 32'({cnt_q, 2'b00})) : '0;

  // Refill FSM: launch on an unflushed miss, consume one word per accepted ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    wr_en   = 1'b0;
    set_en  = 1'b0;
    clr_en  = 1'b0;
    launch  = 1'b0;
    if (rdy) begin
      if (state_q == S_IDLE) begin
        if (fetch_valid && !fetch_hit && !flush) begin
          launch  = 1'b1;
          clr_en  = 1'b1;
          base_d  = line_base;
          cnt_d   = '0;
          state_d = S_REFILL;
        end
      end else if (mem_ack) begin
        wr_en = 1'b1;
        if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
          set_en  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d;

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;

  // Saturating hit/miss counters.
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (rdy && fetch_hit && hits_q != '1) hits_d   = hits_q + 32'd1;
    if (launch && misses_q != '1)         misses_d = misses_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed refill/flush/reset/rdy sequences,
// a table of combinational lookups, and a randomized run against a line model.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst, rdy, fetch_valid, flush, mem_ack;
  logic [31:0] fetch_pc, mem_data;
  logic        fetch_hit, mem_req;
  logic [31:0] fetch_instr, mem_addr;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  icache dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_hit   (fetch_hit),
    .fetch_instr (fetch_instr),
`ifdef ICACHE_STATS_EN
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
`endif
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data)
  );

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic        exp_hit;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Acknowledge words [from..upto] of a refill at base; word k carries seed*(k+1).
  task automatic serve(input logic [31:0] base, input int unsigned from,
                       input int unsigned upto, input logic [31:0] seed);
    for (int unsigned k = from; k <= upto; k++) begin
      mem_ack  = 1'b1;
      mem_data = seed * (k + 1);
      #1;
      chk("refill_req", {31'd0, mem_req}, 32'd1);
      chk("refill_addr", mem_addr, base + 4 * k);
      step();
    end
    mem_ack = 1'b0;
  endtask

  task automatic launch(input logic [31:0] pc);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    flush       = 1'b0;
    mem_ack     = 1'b0;
    #1;
    chk("launch_miss", {31'd0, fetch_hit}, 32'd0);
    step();
  endtask

  task automatic lookup(input string name, input logic [31:0] pc,
                        input logic exp_hit, input logic [31:0] exp_instr);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    #1;
    chk({name, "_hit"}, {31'd0, fetch_hit}, {31'd0, exp_hit});
    chk({name, "_instr"}, fetch_instr, exp_instr);
  endtask

  task automatic reset_dut();
    rst = 1'b1; rdy = 1'b1; fetch_valid = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_data = '0; fetch_pc = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_instr", fetch_instr, 32'd0);
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model state for the random phase.
  logic        mv [64];
  logic [19:0] mt [64];
  bit          refilling;
  logic [31:0] rbase;
  int unsigned rcnt;
  longint      m_hits, m_misses;

  initial begin
    tbl[0] = '{1'b1, 32'h0000_0000, 1'b1, 32'h11};
    tbl[1] = '{1'b1, 32'h0000_0004, 1'b1, 32'h22};
    tbl[2] = '{1'b1, 32'h0000_000B, 1'b1, 32'h33};
    tbl[3] = '{1'b1, 32'h0000_000C, 1'b1, 32'h44};
    tbl[4] = '{1'b0, 32'h0000_000C, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 32'h0000_0010, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 32'h0000_1000, 1'b0, 32'h0};

    reset_dut();

    // Cold miss on 0x8 fills line 0.
    launch(32'h0000_0008);
    serve(32'h0, 0, 3, 32'h11);
    #1;
    chk("cold_hit", {31'd0, fetch_hit}, 32'd1);
    chk("cold_instr", fetch_instr, 32'h33);
    chk("cold_req_off", {31'd0, mem_req}, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("cold_stat_misses", stat_misses, 32'd1);
    chk("cold_stat_hits", stat_hits, 32'd0);
`endif

    // Same-line hit, no new request.
    lookup("same_line", 32'h0000_000C, 1'b1, 32'h44);
    step();
    chk("same_line_req", {31'd0, mem_req}, 32'd0);

    // Combinational lookup table; flush held so no miss can launch.
    flush = 1'b1;
    for (int i = 0; i < 7; i++) begin
      fetch_valid = tbl[i].fv;
      fetch_pc    = tbl[i].pc;
      #1;
      chk($sformatf("tbl%0d_hit", i), {31'd0, fetch_hit}, {31'd0, tbl[i].exp_hit});
      chk($sformatf("tbl%0d_instr", i), fetch_instr, tbl[i].exp_instr);
    end
    step();
    chk("tbl_no_req", {31'd0, mem_req}, 32'd0);

    // Conflict eviction of line 0 by tag 1.
    launch(32'h0000_0400);
    serve(32'h400, 0, 3, 32'hA0);
    lookup("evict_new", 32'h0000_0404, 1'b1, 32'h140);
    lookup("evict_old", 32'h0000_0000, 1'b0, 32'h0);
    step();
    serve(32'h0, 0, 3, 32'h11);

    // Flush masks a miss launch in IDLE, but not an ongoing refill.
    fetch_valid = 1'b1; fetch_pc = 32'h20; flush = 1'b1;
    #1;
    chk("flush_miss_hit", {31'd0, fetch_hit}, 32'd0);
    step();
    chk("flush_no_req", {31'd0, mem_req}, 32'd0);
    flush = 1'b0;
    step();
    serve(32'h20, 0, 1, 32'h7);
    flush = 1'b1;
    serve(32'h20, 2, 3, 32'h7);
    flush = 1'b0;
    lookup("flush_fill", 32'h0000_002C, 1'b1, 32'h1C);

    // Reset in the middle of a refill.
    launch(32'h0000_0040);
    serve(32'h40, 0, 0, 32'h5);
    rst = 1'b1; fetch_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_instr", fetch_instr, 32'd0);
    flush = 1'b1;
    lookup("mid_rst_line0", 32'h0, 1'b0, 32'h0);
    mem_ack = 1'b1; mem_data = 32'hBAD0_BAD0;
    step();
    chk("late_ack_req", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b0; flush = 1'b0;
    step();
    serve(32'h0, 0, 3, 32'h11);

    // rdy low mid-refill with mem_ack held: no progress.
    launch(32'h0000_0050);
    serve(32'h50, 0, 0, 32'h3);
    rdy = 1'b0; mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req", {31'd0, mem_req}, 32'd1);
      chk("stall_addr", mem_addr, 32'h54);
      step();
    end
    rdy = 1'b1;
    serve(32'h50, 1, 3, 32'h3);
    lookup("stall_w1", 32'h54, 1'b1, 32'h6);
    lookup("stall_w0", 32'h50, 1'b1, 32'h3);

    // Randomized run against the line model.
    reset_dut();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    refilling = 0; rcnt = 0; rbase = '0; m_hits = 0; m_misses = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [5:0]  idx;
      logic        eh;
      logic [31:0] ei;
      rdy         = ($urandom_range(7) != 0);
      fetch_valid = ($urandom_range(3) != 0);
      fetch_pc    = (32'($urandom_range(2)) << 12) | (32'($urandom_range(3)) << 4)
                  | (32'($urandom_range(3)) << 2) | 32'($urandom_range(3));
      flush       = ($urandom_range(7) == 0);
      mem_ack     = refilling ? ($urandom_range(1) == 1) : ($urandom_range(3) == 0);
      mem_data    = refilling ? memf(rbase + 4 * rcnt) : $urandom;
      #1;
      idx = fetch_pc[9:4];
      eh  = fetch_valid && mv[idx] && (mt[idx] == fetch_pc[31:12]);
      ei  = eh ? memf({fetch_pc[31:2], 2'b00}) : 32'h0;
      chk("rnd_hit", {31'd0, fetch_hit}, {31'd0, eh});
      chk("rnd_instr", fetch_instr, ei);
      chk("rnd_req", {31'd0, mem_req}, {31'd0, refilling});
      chk("rnd_addr", mem_addr, refilling ? rbase + 4 * rcnt : 32'h0);
      if (rdy) begin
        if (eh) m_hits++;
        if (refilling) begin
          if (mem_ack) begin
            rcnt++;
            if (rcnt == 4) begin
              mv[rbase[9:4]] = 1'b1;
              mt[rbase[9:4]] = rbase[31:12];
              refilling = 0;
              rcnt = 0;
            end
          end
        end else if (fetch_valid && !eh && !flush) begin
          refilling = 1;
          rbase = {fetch_pc[31:4], 4'h0};
          rcnt = 0;
          mv[idx] = 1'b0;
          m_misses++;
        end
      end
      step();
    end
`ifdef ICACHE_STATS_EN
    chk("rnd_stat_hits", stat_hits, 32'(m_hits));
    chk("rnd_stat_misses", stat_misses, 32'(m_misses));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
